// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory and its preload engine.
//   load_state_t : loader FSM encoding
//   LaneLsb      : big-endian byte offset k -> LSB of that byte within the word
//   lane_en()    : byte enables for full, SWL-style and SWR-style stores
package mem_pkg;

  typedef enum logic [1:0] {IDLE, ASSEMBLE, COMMIT, DONE} load_state_t;

  localparam int unsigned WordW    = 32;
  localparam int unsigned LaneW    = 8;
  localparam int unsigned NumLanes = 4;

  // Offset 0 is the most significant byte.
  localparam int unsigned LaneLsb [NumLanes] = '{24, 16, 8, 0};

  // Enable bit k covers big-endian byte offset k.
  // WriteL keeps bytes k..3, WriteR keeps bytes 0..k; neither or both is a full word.
  function automatic logic [NumLanes-1:0] lane_en(input logic [1:0] k,
                                                  input logic       write_l,
                                                  input logic       write_r);
    logic [NumLanes-1:0] all;
    all     = '1;
    lane_en = all;
    if (write_l && !write_r) begin
      lane_en = all << k;
    end else if (write_r && !write_l) begin
      lane_en = all >> (2'd3 - k);
    end
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Byte-serial preload engine. Assembles four bytes (MSB first) into a word and
// commits it to the next RAM word, walking from word 0 to DEPTH-1.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   load_en_i              session enable; dropping it returns to IDLE next cycle
//   load_valid_i           load_byte_i is valid
//   load_byte_i            preload byte
//   load_ready_o           byte accepted this cycle when valid (depends on state only)
//   load_done_o            every word has been committed
//   commit_o               one-cycle write strobe into the RAM write port
//   commit_addr_o          word index for the commit
//   commit_data_o          assembled word
module mem_loader
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_en_i,
  input  logic             load_valid_i,
  input  logic [LaneW-1:0] load_byte_i,
  output logic             load_ready_o,
  output logic             load_done_o,
  output logic             commit_o,
  output logic [AW-1:0]    commit_addr_o,
  output logic [WordW-1:0] commit_data_o
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  load_state_t      state_q, state_d;
  logic [AW-1:0]    load_addr_q, load_addr_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [WordW-1:0] shift_q, shift_d;

  always_comb begin
    state_d      = state_q;
    load_addr_d  = load_addr_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    load_ready_o = 1'b0;
    load_done_o  = 1'b0;
    commit_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_en_i) begin
          state_d     = ASSEMBLE;
          load_addr_d = '0;
          byte_cnt_d  = '0;
        end
      end
      ASSEMBLE: begin
        load_ready_o = 1'b1;
        if (!load_en_i) begin
          // Partial word is simply dropped.
          state_d = IDLE;
        end else if (load_valid_i) begin
          shift_d    = {shift_q[WordW-LaneW-1:0], load_byte_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        // The write happens on this edge regardless of load_en_i.
        commit_o = 1'b1;
        if (!load_en_i) begin
          state_d = IDLE;
        end else if (load_addr_q == LastAddr) begin
          state_d = DONE;
        end else begin
          load_addr_d = load_addr_q + AW'(1);
          byte_cnt_d  = '0;
          state_d     = ASSEMBLE;
        end
      end
      DONE: begin
        load_done_o = 1'b1;
        if (!load_en_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      load_addr_q <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
    end
  end

  assign commit_addr_o = load_addr_q;
  assign commit_data_o = shift_q;

endmodule

// File: rtl/data_mem.sv
// Data-memory responder for the core's load/store port. Word-organised,
// big-endian RAM with byte-lane writes for SWL/SWR merges, one-cycle registered
// read data, and a byte-serial preload engine sharing the single write port.
// Ports:
//   Clock, nReset                 clock, asynchronous active-low reset
//   MemAddr                       byte address; word index = MemAddr[AW+1:2], offset = [1:0]
//   MemRead / MemWrite            read / write request
//   WriteL / WriteR               SWL / SWR partial-word store
//   WriteData                     lane-aligned store data
//   MemData                       registered read word (old data on same-index read+write)
//   LoadEn, LoadValid, LoadByte   preload session and byte stream
//   LoadReady, LoadDone           preload handshake and completion
module data_mem
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] MemAddr,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        WriteL,
  input  logic        WriteR,
  input  logic [31:0] WriteData,
  output logic [31:0] MemData,
  input  logic        LoadEn,
  input  logic        LoadValid,
  input  logic [7:0]  LoadByte,
  output logic        LoadReady,
  output logic        LoadDone
);

  logic [AW-1:0]       core_idx;
  logic                ld_commit;
  logic [AW-1:0]       ld_addr;
  logic [WordW-1:0]    ld_data;

  logic                wr_en;
  logic [AW-1:0]       wr_idx;
  logic [WordW-1:0]    wr_data;
  logic [NumLanes-1:0] wr_be;

  logic [WordW-1:0]    rd_word;
  logic [WordW-1:0]    mem_data_q, mem_data_d;

  // Upper address bits wrap the index modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^MemAddr;

  assign core_idx = MemAddr[AW+1:2];

  mem_loader #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_loader (
    .clk_i         (Clock),
    .rst_ni        (nReset),
    .load_en_i     (LoadEn),
    .load_valid_i  (LoadValid),
    .load_byte_i   (LoadByte),
    .load_ready_o  (LoadReady),
    .load_done_o   (LoadDone),
    .commit_o      (ld_commit),
    .commit_addr_o (ld_addr),
    .commit_data_o (ld_data)
  );

  // Loader owns the write port during a session, and also for a commit that
  // completes in the cycle LoadEn falls.
  always_comb begin
    wr_en   = MemWrite;
    wr_idx  = core_idx;
    wr_data = WriteData;
    wr_be   = lane_en(MemAddr[1:0], WriteL, WriteR);
    if (LoadEn || ld_commit) begin
      wr_en   = ld_commit;
      wr_idx  = ld_addr;
      wr_data = ld_data;
      wr_be   = '1;
    end
  end

  // One RAM per byte lane so each enable maps to an independent write.
  for (genvar g = 0; g < NumLanes; g++) begin : g_lane
    logic [LaneW-1:0] ram_q [DEPTH];

    always_ff @(posedge Clock) begin
      if (wr_en && wr_be[g]) begin
        ram_q[wr_idx] <= wr_data[LaneLsb[g] +: LaneW];
      end
    end

    assign rd_word[LaneLsb[g] +: LaneW] = ram_q[core_idx];
  end

  // Read samples the pre-write contents, giving read-before-write.
  always_comb begin
    mem_data_d = mem_data_q;
    if (MemRead) begin
      mem_data_d = rd_word;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      mem_data_q <= '0;
    end else begin
      mem_data_q <= mem_data_d;
    end
  end

  assign MemData = mem_data_q;

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  logic        clk;
  logic        n_reset;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic        write_l;
  logic        write_r;
  logic [31:0] write_data;
  logic        load_en;
  logic        load_valid;
  logic [7:0]  load_byte;

  logic [31:0] mem_data_b, mem_data_s;
  logic        load_ready_b, load_ready_s;
  logic        load_done_b, load_done_s;

  int checks = 0;
  int errors = 0;

  data_mem #(.DEPTH(1024)) u_big (
    .Clock     (clk),
    .nReset    (n_reset),
    .MemAddr   (mem_addr),
    .MemRead   (mem_read),
    .MemWrite  (mem_write),
    .WriteL    (write_l),
    .WriteR    (write_r),
    .WriteData (write_data),
    .MemData   (mem_data_b),
    .LoadEn    (load_en),
    .LoadValid (load_valid),
    .LoadByte  (load_byte),
    .LoadReady (load_ready_b),
    .LoadDone  (load_done_b)
  );

  data_mem #(.DEPTH(4)) u_small (
    .Clock     (clk),
    .nReset    (n_reset),
    .MemAddr   (mem_addr),
    .MemRead   (mem_read),
    .MemWrite  (mem_write),
    .WriteL    (write_l),
    .WriteR    (write_r),
    .WriteData (write_data),
    .MemData   (mem_data_s),
    .LoadEn    (load_en),
    .LoadValid (load_valid),
    .LoadByte  (load_byte),
    .LoadReady (load_ready_s),
    .LoadDone  (load_done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic l, input logic r);
    @(negedge clk);
    mem_addr   = a;
    write_data = d;
    write_l    = l;
    write_r    = r;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    write_l   = 1'b0;
    write_r   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] db, output logic [31:0] ds);
    @(negedge clk);
    mem_addr = a;
    mem_read = 1'b1;
    @(posedge clk);
    #1;
    db       = mem_data_b;
    ds       = mem_data_s;
    mem_read = 1'b0;
  endtask

  // Drives bytes first, first+1, ... until n are accepted, within a cycle budget.
  task automatic feed(input int n, input logic [7:0] first);
    int   acc;
    logic rdy;
    acc = 0;
    for (int cyc = 0; cyc < 10 * n && acc < n; cyc++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_byte  = first + 8'(acc);
      rdy        = load_ready_s;
      @(posedge clk);
      #1;
      if (rdy) acc++;
    end
    load_valid = 1'b0;
    checks++;
    if (acc !== n) begin
      errors++;
      $display("FAIL feed accepted %0d bytes, required %0d", acc, n);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    #12;
    checks++; if (mem_data_b !== 32'h0) begin errors++; $display("FAIL reset_memdata_big got %h want 0", mem_data_b); end
    checks++; if (mem_data_s !== 32'h0) begin errors++; $display("FAIL reset_memdata_small got %h want 0", mem_data_s); end
    checks++; if (load_ready_b !== 1'b0) begin errors++; $display("FAIL reset_ready_big got %b want 0", load_ready_b); end
    checks++; if (load_ready_s !== 1'b0) begin errors++; $display("FAIL reset_ready_small got %b want 0", load_ready_s); end
    checks++; if (load_done_b !== 1'b0) begin errors++; $display("FAIL reset_done_big got %b want 0", load_done_b); end
    checks++; if (load_done_s !== 1'b0) begin errors++; $display("FAIL reset_done_small got %b want 0", load_done_s); end
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (mem_data_b !== 32'h0) begin errors++; $display("FAIL post_reset_memdata got %h want 0", mem_data_b); end
  endtask

  task automatic test_full_word();
    logic [31:0] db, ds;
    wr(16'h0010, 32'hDEADBEEF, 1'b0, 1'b0);
    rd(16'h0010, db, ds);
    checks++; if (db !== 32'hDEADBEEF) begin errors++; $display("FAIL full_word got %h want deadbeef", db); end
    @(negedge clk);
    mem_addr = 16'h0020;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_data_b !== 32'hDEADBEEF) begin errors++; $display("FAIL hold got %h want deadbeef", mem_data_b); end
  endtask

  task automatic test_partial();
    logic [31:0] db, ds;
    wr(16'h0020, 32'h11223344, 1'b0, 1'b0);
    wr(16'h0022, 32'hAABBCCDD, 1'b1, 1'b0);
    rd(16'h0020, db, ds);
    checks++; if (db !== 32'h1122CCDD) begin errors++; $display("FAIL swl_k2 got %h want 1122ccdd", db); end
    wr(16'h0021, 32'h99887766, 1'b0, 1'b1);
    rd(16'h0020, db, ds);
    checks++; if (db !== 32'h9988CCDD) begin errors++; $display("FAIL swr_k1 got %h want 9988ccdd", db); end
    wr(16'h0030, 32'h01020304, 1'b0, 1'b0);
    wr(16'h0033, 32'hFFEEDDCC, 1'b1, 1'b0);
    rd(16'h0030, db, ds);
    checks++; if (db !== 32'h010203CC) begin errors++; $display("FAIL swl_k3 got %h want 010203cc", db); end
    wr(16'h0030, 32'h55667788, 1'b0, 1'b1);
    rd(16'h0030, db, ds);
    checks++; if (db !== 32'h550203CC) begin errors++; $display("FAIL swr_k0 got %h want 550203cc", db); end
    wr(16'h0032, 32'hA1B2C3D4, 1'b1, 1'b1);
    rd(16'h0030, db, ds);
    checks++; if (db !== 32'hA1B2C3D4) begin errors++; $display("FAIL both_lr got %h want a1b2c3d4", db); end
    wr(16'h0031, 32'h0BADF00D, 1'b0, 1'b0);
    rd(16'h0030, db, ds);
    checks++; if (db !== 32'h0BADF00D) begin errors++; $display("FAIL full_ignores_k got %h want 0badf00d", db); end
  endtask

  task automatic test_read_before_write();
    logic [31:0] db, ds;
    wr(16'h0040, 32'h00000001, 1'b0, 1'b0);
    @(negedge clk);
    mem_addr   = 16'h0040;
    write_data = 32'h00000002;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    checks++; if (mem_data_b !== 32'h00000001) begin errors++; $display("FAIL rbw_old got %h want 00000001", mem_data_b); end
    rd(16'h0040, db, ds);
    checks++; if (db !== 32'h00000002) begin errors++; $display("FAIL rbw_new got %h want 00000002", db); end
  endtask

  task automatic test_wrap();
    logic [31:0] db, ds;
    wr(16'h1004, 32'hCAFE0000, 1'b0, 1'b0);
    rd(16'h0004, db, ds);
    checks++; if (db !== 32'hCAFE0000) begin errors++; $display("FAIL wrap got %h want cafe0000", db); end
  endtask

  task automatic test_loader();
    logic [31:0] exp_w [4];
    logic [31:0] db, ds;
    logic        rdy;
    int          b;
    exp_w = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    b = 0;
    @(negedge clk);
    load_en    = 1'b1;
    load_valid = 1'b1;
    load_byte  = 8'h00;
    @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rdy = load_ready_s;
      checks++;
      if (rdy !== ((c % 5) != 4)) begin
        errors++;
        $display("FAIL loader_ready cycle %0d got %b want %b", c, rdy, ((c % 5) != 4));
      end
      load_byte = 8'(b);
      @(posedge clk);
      #1;
      if (rdy) b++;
    end
    load_valid = 1'b0;
    @(negedge clk);
    checks++; if (b !== 16) begin errors++; $display("FAIL loader_bytes got %0d want 16", b); end
    checks++; if (load_done_s !== 1'b1) begin errors++; $display("FAIL loader_done got %b want 1", load_done_s); end
    checks++; if (load_done_b !== 1'b0) begin errors++; $display("FAIL loader_done_big got %b want 0", load_done_b); end
    for (int i = 0; i < 4; i++) begin
      rd(16'(i * 4), db, ds);
      checks++;
      if (ds !== exp_w[i]) begin errors++; $display("FAIL loader_word%0d got %h want %h", i, ds, exp_w[i]); end
    end
    @(negedge clk);
    load_en = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (load_done_s !== 1'b0) begin errors++; $display("FAIL loader_done_clear got %b want 0", load_done_s); end
  endtask

  task automatic test_abort();
    logic [31:0] db, ds;
    // Core write issued in the same cycle the session opens must be dropped.
    @(negedge clk);
    load_en    = 1'b1;
    mem_addr   = 16'h0008;
    write_data = 32'hBAD0BAD0;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    feed(6, 8'hA0);
    @(negedge clk);
    load_en = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (load_ready_s !== 1'b0) begin errors++; $display("FAIL abort_idle_ready got %b want 0", load_ready_s); end
    rd(16'h0000, db, ds);
    checks++; if (ds !== 32'hA0A1A2A3) begin errors++; $display("FAIL abort_word0 got %h want a0a1a2a3", ds); end
    rd(16'h0004, db, ds);
    checks++; if (ds !== 32'h04050607) begin errors++; $display("FAIL abort_word1 got %h want 04050607", ds); end
    rd(16'h0008, db, ds);
    checks++; if (ds !== 32'h08090A0B) begin errors++; $display("FAIL core_write_gated got %h want 08090a0b", ds); end
    // Restart must begin again at word 0.
    @(negedge clk);
    load_en = 1'b1;
    feed(4, 8'hB0);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    load_en = 1'b0;
    @(posedge clk);
    #1;
    rd(16'h0000, db, ds);
    checks++; if (ds !== 32'hB0B1B2B3) begin errors++; $display("FAIL restart_word0 got %h want b0b1b2b3", ds); end
    rd(16'h0004, db, ds);
    checks++; if (ds !== 32'h04050607) begin errors++; $display("FAIL restart_word1 got %h want 04050607", ds); end
  endtask

  initial begin
    mem_addr   = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_l    = 1'b0;
    write_r    = 1'b0;
    write_data = '0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    load_byte  = '0;
    test_reset();
    test_full_word();
    test_partial();
    test_read_before_write();
    test_wrap();
    test_loader();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
